// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display
// sharing a single 7448 decoder. It produces per-slot decoder controls
// (BCD/LT/BI/RBI), one-hot digit enables with an anti-ghosting guard,
// leading-zero suppression, lamp test (including a power-up test) and a
// one-deep load buffer that is committed only on frame boundaries.
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int GUARD      = 2,
  parameter int LT_FRAMES  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic                      lz_en,
  input  logic                      blank,
  input  logic                      lamp_test,
  output logic [3:0]                BCD,
  output logic                      LT,
  output logic                      BI,
  output logic                      RBI,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LW = (LT_FRAMES > 0) ? $clog2(LT_FRAMES + 1) : 1;
  localparam int NW = 4 * NUM_DIGITS;

  localparam logic [IW-1:0] MSD      = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [LW-1:0] LT_INIT  = LW'(LT_FRAMES);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  // ST_START is the single cycle between reset release and cycle 0 of the
  // first MSD slot; ST_SCAN is steady-state scanning.
  typedef enum logic {ST_START, ST_SCAN} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [LW-1:0]           lt_cnt_reg, lt_cnt_next;
  logic [NW-1:0]           active_reg, active_next;
  logic [NW-1:0]           pending_reg, pending_next;
  logic                    pending_full_reg, pending_full_next;
  logic [3:0]              bcd_reg, bcd_next;
  logic                    lt_reg, lt_next;
  logic                    bi_reg, bi_next;
  logic                    rbi_reg, rbi_next;
  logic [NUM_DIGITS-1:0]   dig_en_reg, dig_en_next;
  logic                    frame_start_reg, frame_start_next;

  logic                    xfer;
  logic                    slot_load;
  logic                    frame_load;
  logic [CW-1:0]           cnt_inc;
  logic                    upper_zero;
  logic                    rbi_lz;

  assign data_ready  = ~pending_full_reg;
  assign BCD         = bcd_reg;
  assign LT          = lt_reg;
  assign BI          = bi_reg;
  assign RBI         = rbi_reg;
  assign dig_en      = dig_en_reg;
  assign frame_start = frame_start_reg;

  // State register: every output and buffer is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_START;
      cnt_reg          <= '0;
      idx_reg          <= MSD;
      lt_cnt_reg       <= LT_INIT;
      active_reg       <= '0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      bcd_reg          <= 4'd0;
      lt_reg           <= 1'b1;
      bi_reg           <= 1'b0;
      rbi_reg          <= 1'b1;
      dig_en_reg       <= '0;
      frame_start_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      lt_cnt_reg       <= lt_cnt_next;
      active_reg       <= active_next;
      pending_reg      <= pending_next;
      pending_full_reg <= pending_full_next;
      bcd_reg          <= bcd_next;
      lt_reg           <= lt_next;
      bi_reg           <= bi_next;
      rbi_reg          <= rbi_next;
      dig_en_reg       <= dig_en_next;
      frame_start_reg  <= frame_start_next;
    end
  end

  // Next-state: slot timing, buffer handoff and per-slot decoder controls.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    idx_next          = idx_reg;
    lt_cnt_next       = lt_cnt_reg;
    active_next       = active_reg;
    pending_next      = pending_reg;
    pending_full_next = pending_full_reg;
    bcd_next          = bcd_reg;
    lt_next           = lt_reg;
    bi_next           = bi_reg;
    rbi_next          = rbi_reg;
    dig_en_next       = dig_en_reg;
    frame_start_next  = 1'b0;
    slot_load         = 1'b0;
    frame_load        = 1'b0;
    cnt_inc           = cnt_reg + 1'b1;
    upper_zero        = 1'b1;
    rbi_lz            = 1'b1;

    // Accept a word whenever the pending slot is free.
    xfer = data_valid && !pending_full_reg;
    if (xfer) begin
      pending_next      = data_in;
      pending_full_next = 1'b1;
    end

    case (state_reg)
      ST_START: begin
        state_next = ST_SCAN;
        cnt_next   = '0;
        idx_next   = MSD;
        slot_load  = 1'b1;
        frame_load = 1'b1;
      end
      default: begin
        if (cnt_reg == LAST) begin
          cnt_next  = '0;
          slot_load = 1'b1;
          if (idx_reg == '0) begin
            idx_next   = MSD;
            frame_load = 1'b1;
            // The power-up test frame counter ticks on every frame start
            // except the very first one after reset.
            if (lt_cnt_reg != '0)
              lt_cnt_next = lt_cnt_reg - 1'b1;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end else begin
          cnt_next    = cnt_inc;
          dig_en_next = (cnt_inc >= GUARD_C) ? (ONE_HOT0 << idx_reg) : '0;
        end
      end
    endcase

    // Commit the pending word at a frame boundary. pending_next already
    // includes a word accepted on this same edge, so data arriving in the
    // last LSD cycle lands in the frame that begins next.
    if (frame_load && pending_full_next) begin
      active_next       = pending_next;
      pending_full_next = 1'b0;
    end

    // Leading-zero chain evaluated from MSD downward on the word that the
    // new slot will display.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i == int'(idx_next))
        rbi_lz = ~(lz_en && upper_zero);
      upper_zero = upper_zero && (active_next[4*i +: 4] == 4'd0);
    end
    if (idx_next == '0)
      rbi_lz = 1'b1;

    if (slot_load) begin
      dig_en_next      = '0;
      frame_start_next = frame_load;
      bcd_next         = active_next[4*idx_next +: 4];
      if (blank) begin
        bi_next  = 1'b0;
        lt_next  = 1'b1;
        rbi_next = rbi_lz;
      end else if (lamp_test || (lt_cnt_next != '0)) begin
        lt_next  = 1'b0;
        bi_next  = 1'b1;
        rbi_next = 1'b1;
      end else begin
        lt_next  = 1'b1;
        bi_next  = 1'b1;
        rbi_next = rbi_lz;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl: stimulus queues expected per-slot
// decoder values, a monitor checks each slot as its digit enable rises.
module tb_bcd_scan_ctrl;

  localparam int ND = 4;

  logic          clk;
  logic          rst;
  logic [15:0]   data_in;
  logic          data_valid;
  logic          data_ready;
  logic          lz_en;
  logic          blank;
  logic          lamp_test;
  logic [3:0]    bcd;
  logic          lt;
  logic          bi;
  logic          rbi;
  logic [ND-1:0] dig_en;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  // {dig_en, BCD, LT, BI, RBI}
  logic [10:0] exp_q[$];
  logic [3:0]  prev_dig;

  bcd_scan_ctrl #(
    .NUM_DIGITS(ND), .SCAN_DIV(8), .GUARD(1), .LT_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .lz_en(lz_en), .blank(blank),
    .lamp_test(lamp_test), .BCD(bcd), .LT(lt), .BI(bi), .RBI(rbi),
    .dig_en(dig_en), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per slot, taken in the first enabled cycle.
  always @(negedge clk) begin
    if (dig_en != 4'b0000 && prev_dig == 4'b0000 && exp_q.size() > 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      $display("slot dig=%b bcd=%h lt=%b bi=%b rbi=%b (exp %h)",
               dig_en, bcd, lt, bi, rbi, e);
      check("slot", {dig_en, bcd, lt, bi, rbi}, e);
    end
    prev_dig <= dig_en;
  end

  task automatic push_frame(input logic [15:0] v, input logic [3:0] rbis,
                            input logic elt, input logic ebi);
    logic [3:0] d;
    for (int k = 3; k >= 0; k--) begin
      d = 4'b0001 << k;
      exp_q.push_back({d, v[4*k +: 4], elt, ebi, rbis[k]});
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 200);
    check("frame_start_seen", frame_start, 1);
  endtask

  task automatic wait_dig(input logic [3:0] target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig_en != target && n < 200);
    check("dig_seen", dig_en, target);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic load(input logic [15:0] v);
    int n = 0;
    while (!data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_for_load", data_ready, 1);
    data_in    = v;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ed;
    int n_early;
    rst = 1'b1; data_in = 16'h0; data_valid = 1'b0;
    lz_en = 1'b0; blank = 1'b0; lamp_test = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_values", {dig_en, bcd, lt, bi, rbi, frame_start, data_ready},
          {4'b0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});

    // T1: power-up lamp test for two full frames.
    rst = 1'b0;
    push_frame(16'h0000, 4'b1111, 1'b0, 1'b1);
    push_frame(16'h0000, 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      ed = (i % 8 == 0) ? 4'b0000 : (4'b1000 >> ((i / 8) % 4));
      check("t1_cycle", {dig_en, lt, frame_start},
            {ed, (i < 64) ? 1'b0 : 1'b1, (i % 32 == 0) ? 1'b1 : 1'b0});
    end

    // T2: normal load, no suppression.
    load(16'h1234);
    wait_frame();
    push_frame(16'h1234, 4'b1111, 1'b1, 1'b1);
    drain();

    // T3: leading-zero suppression.
    lz_en = 1'b1;
    load(16'h0050);
    wait_frame();
    push_frame(16'h0050, 4'b0001, 1'b1, 1'b1);
    drain();
    load(16'h0000);
    wait_frame();
    push_frame(16'h0000, 4'b0001, 1'b1, 1'b1);
    drain();
    load(16'h0705);
    wait_frame();
    push_frame(16'h0705, 4'b0011, 1'b1, 1'b1);
    drain();

    // T4: mid-frame load, then a second word held across the boundary.
    lz_en = 1'b0;
    wait_frame();
    push_frame(16'h0705, 4'b1111, 1'b1, 1'b1);
    wait_dig(4'b0100);
    load(16'h1111);
    check("t4_ready_low", data_ready, 0);
    data_in = 16'h2222;
    data_valid = 1'b1;
    n_early = 0;
    for (int n = 0; n < 100 && !frame_start; n++) begin
      if (data_ready) n_early++;
      @(negedge clk);
    end
    check("t4_ready_held_low", n_early, 0);
    check("t4_ready_at_boundary", data_ready, 1);
    push_frame(16'h1111, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_second_accepted", data_ready, 0);
    data_valid = 1'b0;
    wait_frame();
    push_frame(16'h2222, 4'b1111, 1'b1, 1'b1);
    drain();

    // T5: blank over lamp test, then lamp test, then normal.
    blank = 1'b1;
    lamp_test = 1'b1;
    wait_frame();
    exp_q.push_back({4'b1000, 4'h2, 1'b1, 1'b0, 1'b1});
    wait_dig(4'b1000);
    blank = 1'b0;
    exp_q.push_back({4'b0100, 4'h2, 1'b0, 1'b1, 1'b1});
    wait_dig(4'b0100);
    lamp_test = 1'b0;
    exp_q.push_back({4'b0010, 4'h2, 1'b1, 1'b1, 1'b1});
    exp_q.push_back({4'b0001, 4'h2, 1'b1, 1'b1, 1'b1});
    drain();

    // T6: reset during digit-1 slot with a pending word.
    wait_dig(4'b0010);
    load(16'h3333);
    check("t6_pending", data_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_reset_values", {dig_en, bcd, lt, bi, rbi, frame_start, data_ready},
          {4'b0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    rst = 1'b0;
    push_frame(16'h0000, 4'b1111, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_frame_start", frame_start, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
